// File: rtl/cpu.sv
// Multi-cycle 16-bit von Neumann CPU: package, unified memory, register file,
// datapath and the FETCH/DECODE/EXEC/MEMORY/WB/HALT controller.

package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEMORY = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_SLL  = 4'hD;
  localparam logic [3:0] OP_RSV  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

endpackage

// Unified instruction/data memory: combinational read, posedge write, never reset.
module cpu_mem (
  input  logic        clk,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);

  logic [15:0] mem [0:65535];

  assign rdata = mem[addr];

  // Store one word; contents survive reset so preloaded programs are kept
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// Eight 16-bit registers, R0 hard-wired to zero on read and write.
module cpu_rf (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  raddr_a,
  input  logic [2:0]  raddr_b,
  output logic [15:0] rdata_a,
  output logic [15:0] rdata_b
);

  logic [15:0] registers [0:7];

  assign rdata_a = (raddr_a == 3'd0) ? 16'h0000 : registers[raddr_a];
  assign rdata_b = (raddr_b == 3'd0) ? 16'h0000 : registers[raddr_b];

  // Clear all registers on reset; otherwise write back, dropping writes to R0
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        registers[i] <= 16'h0000;
      end
    end else if (we && (waddr != 3'd0)) begin
      registers[waddr] <= wdata;
    end
  end

endmodule

// Datapath: PC, IR, operand latches, ALU, MDR and the memory/register ports.
module cpu_datapath
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  state_t     state,
  output logic [3:0] op
);

  logic [15:0] PC_q;
  logic [15:0] IR_q;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [15:0] alu_r;
  logic [15:0] mdr_r;

  logic [2:0]  rd_s;
  logic [2:0]  rs_s;
  logic [2:0]  rt_s;
  logic [15:0] imm6_sext_s;
  logic [15:0] imm9_zext_s;
  logic [15:0] imm12_zext_s;
  logic [2:0]  rf_raddr_b_s;
  logic [15:0] rf_rdata_a_s;
  logic [15:0] rf_rdata_b_s;
  logic        rf_we_s;
  logic [15:0] rf_wdata_s;
  logic [15:0] mem_addr_s;
  logic        mem_we_s;
  logic [15:0] mem_rdata_s;
  logic [15:0] alu_s;
  logic        branch_taken_s;

  assign op           = IR_q[15:12];
  assign rd_s         = IR_q[11:9];
  assign rs_s         = IR_q[8:6];
  assign rt_s         = IR_q[5:3];
  assign imm6_sext_s  = {{10{IR_q[5]}}, IR_q[5:0]};
  assign imm9_zext_s  = {7'b000_0000, IR_q[8:0]};
  assign imm12_zext_s = {4'b0000, IR_q[11:0]};

  // Second read port carries rd for ST data and branch compares, rt otherwise
  always_comb begin
    rf_raddr_b_s = rt_s;
    if ((op == OP_ST) || (op == OP_BEQ) || (op == OP_BNE)) begin
      rf_raddr_b_s = rd_s;
    end else begin
      rf_raddr_b_s = rt_s;
    end
  end

  // ALU: arithmetic/logic result, immediate loads and LD/ST effective address
  always_comb begin
    alu_s = 16'h0000;
    case (op)
      OP_ADD:         alu_s = a_r + b_r;
      OP_SUB:         alu_s = a_r - b_r;
      OP_AND:         alu_s = a_r & b_r;
      OP_OR:          alu_s = a_r | b_r;
      OP_XOR:         alu_s = a_r ^ b_r;
      OP_ADDI:        alu_s = a_r + imm6_sext_s;
      OP_LDI:         alu_s = imm9_zext_s;
      OP_LD, OP_ST:   alu_s = a_r + imm6_sext_s;
      OP_SLL:         alu_s = a_r << IR_q[3:0];
      default:        alu_s = 16'h0000;
    endcase
  end

  // Branch decision compares R[rd] (B) against R[rs] (A)
  always_comb begin
    branch_taken_s = 1'b0;
    if (op == OP_BEQ) begin
      branch_taken_s = (a_r == b_r);
    end else if (op == OP_BNE) begin
      branch_taken_s = (a_r != b_r);
    end else begin
      branch_taken_s = 1'b0;
    end
  end

  // Memory port is shared: PC during FETCH, the effective address afterwards
  always_comb begin
    mem_addr_s = alu_r;
    mem_we_s   = 1'b0;
    if (state == FETCH) begin
      mem_addr_s = PC_q;
    end else begin
      mem_addr_s = alu_r;
    end
    if ((state == MEMORY) && (op == OP_ST) && !reset) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Write-back selects MDR for loads, the ALU result for everything else
  always_comb begin
    rf_we_s    = (state == WB) && !reset;
    rf_wdata_s = alu_r;
    if (op == OP_LD) begin
      rf_wdata_s = mdr_r;
    end else begin
      rf_wdata_s = alu_r;
    end
  end

  // Per-state datapath register updates
  always_ff @(posedge clk) begin
    if (reset) begin
      PC_q  <= 16'h0000;
      IR_q  <= 16'h0000;
      a_r   <= 16'h0000;
      b_r   <= 16'h0000;
      alu_r <= 16'h0000;
      mdr_r <= 16'h0000;
    end else begin
      case (state)
        FETCH: begin
          IR_q <= mem_rdata_s;
          PC_q <= PC_q + 16'd1;
        end
        DECODE: begin
          a_r <= rf_rdata_a_s;
          b_r <= rf_rdata_b_s;
        end
        EXEC: begin
          alu_r <= alu_s;
          if (op == OP_JMP) begin
            PC_q <= imm12_zext_s;
          end else if (branch_taken_s) begin
            PC_q <= PC_q + imm6_sext_s;
          end
        end
        MEMORY: begin
          if (op == OP_LD) begin
            mdr_r <= mem_rdata_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  cpu_mem MEM (
    .clk   (clk),
    .we    (mem_we_s),
    .addr  (mem_addr_s),
    .wdata (b_r),
    .rdata (mem_rdata_s)
  );

  cpu_rf RF (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we_s),
    .waddr   (rd_s),
    .wdata   (rf_wdata_s),
    .raddr_a (rs_s),
    .raddr_b (rf_raddr_b_s),
    .rdata_a (rf_rdata_a_s),
    .rdata_b (rf_rdata_b_s)
  );

endmodule

// Top level: sequencing FSM around the datapath.
module cpu
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic Halt
);

  state_t     state_r;
  state_t     next_s;
  logic       halt_r;
  logic [3:0] op_s;

  assign Halt = halt_r;

  // State register; Halt is registered alongside so it rises with HALT entry
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
      halt_r  <= 1'b0;
    end else begin
      state_r <= next_s;
      halt_r  <= (next_s == HALT);
    end
  end

  // Next-state decode from the current state and the latched opcode
  always_comb begin
    next_s = state_r;
    case (state_r)
      FETCH: next_s = DECODE;
      DECODE: begin
        if (op_s == OP_HLT) begin
          next_s = HALT;
        end else if ((op_s == OP_NOP) || (op_s == OP_RSV)) begin
          next_s = FETCH;
        end else begin
          next_s = EXEC;
        end
      end
      EXEC: begin
        if ((op_s == OP_BEQ) || (op_s == OP_BNE) || (op_s == OP_JMP)) begin
          next_s = FETCH;
        end else if ((op_s == OP_LD) || (op_s == OP_ST)) begin
          next_s = MEMORY;
        end else begin
          next_s = WB;
        end
      end
      MEMORY: begin
        if (op_s == OP_LD) begin
          next_s = WB;
        end else begin
          next_s = FETCH;
        end
      end
      WB:      next_s = FETCH;
      HALT:    next_s = HALT;
      default: next_s = FETCH;
    endcase
  end

  cpu_datapath DP (
    .clk   (clk),
    .reset (reset),
    .state (state_r),
    .op    (op_s)
  );

endmodule

// File: tb/tb_cpu.sv
// Program-level bench for cpu: a table of programs with expected register,
// memory and halt-cycle results queued as a scoreboard and checked at Halt.
module tb_cpu;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic Halt;

  int checks = 0;
  int failures = 0;

  cpu dut (
    .clk   (clk),
    .reset (reset),
    .Halt  (Halt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]       name;
    logic [15:0][15:0] prog;
    logic [4:0]        nwords;
    logic [7:0]        halt_cyc;
    logic [3:0][2:0]   ridx;
    logic [3:0][15:0]  rval;
    logic [2:0]        nreg;
    logic [15:0]       maddr;
    logic [15:0]       mval;
    logic              chk_mem;
  } vec_t;

  typedef struct {
    string       name;
    int          kind;  // 0 register, 1 memory word, 2 halt cycle count
    int          idx;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic push_exp(input string nm, input int kind, input int idx, input logic [15:0] val);
    exp_t e;
    e.name = nm;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic enter_reset(input vec_t v, input bit load);
    @(negedge clk);
    reset = 1'b1;
    if (load) begin
      for (int a = 0; a < 64; a++) dut.DP.MEM.mem[a] = 16'h0000;
      for (int i = 0; i < 16; i++) begin
        if (i < int'(v.nwords)) dut.DP.MEM.mem[i] = v.prog[i];
      end
    end
    repeat (2) @(negedge clk);
    check("rst_pc", dut.DP.PC_q, 16'h0000);
    check("rst_ir", dut.DP.IR_q, 16'h0000);
    check("rst_halt", {15'h0000, Halt}, 16'h0000);
    for (int r = 1; r <= 5; r++) begin
      check($sformatf("rst_R%0d", r), dut.DP.RF.registers[r], 16'h0000);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit load);
    int   cyc;
    bit   done;
    exp_t e;
    enter_reset(v, load);
    push_exp($sformatf("%s_halt_cycles", v.name), 2, 0, {8'h00, v.halt_cyc});
    for (int i = 0; i < int'(v.nreg); i++) begin
      push_exp($sformatf("%s_R%0d", v.name, v.ridx[i]), 0, int'(v.ridx[i]), v.rval[i]);
    end
    if (v.chk_mem) push_exp($sformatf("%s_mem_%h", v.name, v.maddr), 1, int'(v.maddr), v.mval);
    reset = 1'b0;
    cyc = 0;
    done = 1'b0;
    while (!done && (cyc < 500)) begin
      @(posedge clk);
      #1;
      cyc++;
      if (Halt) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_halt_timeout actual=no_halt required=halt_within_500", v.name);
      sb.delete();
    end else begin
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.kind)
          0:       check(e.name, dut.DP.RF.registers[e.idx], e.val);
          1:       check(e.name, dut.DP.MEM.mem[e.idx], e.val);
          default: check(e.name, cyc[15:0], e.val);
        endcase
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) vecs[i] = '0;

    // Integration program
    vecs[0].name = "integ"; vecs[0].nwords = 5'd6; vecs[0].halt_cyc = 8'd22;
    vecs[0].prog[0] = 16'h7205; vecs[0].prog[1] = 16'h7408; vecs[0].prog[2] = 16'h1A50;
    vecs[0].prog[3] = 16'h7620; vecs[0].prog[4] = 16'h94C0; vecs[0].prog[5] = 16'hF000;
    vecs[0].nreg = 3'd4;
    vecs[0].ridx[0] = 3'd5; vecs[0].rval[0] = 16'h000D;
    vecs[0].ridx[1] = 3'd1; vecs[0].rval[1] = 16'h0005;
    vecs[0].ridx[2] = 3'd2; vecs[0].rval[2] = 16'h0008;
    vecs[0].ridx[3] = 3'd3; vecs[0].rval[3] = 16'h0020;
    vecs[0].chk_mem = 1'b1; vecs[0].maddr = 16'h0020; vecs[0].mval = 16'h0008;

    // Branch loop: BNE taken twice -> 4 + 3*(4+3) + 2 = 27 cycles
    vecs[1].name = "bloop"; vecs[1].nwords = 5'd4; vecs[1].halt_cyc = 8'd27;
    vecs[1].prog[0] = 16'h7203; vecs[1].prog[1] = 16'h627F;
    vecs[1].prog[2] = 16'hB23E; vecs[1].prog[3] = 16'hF000;
    vecs[1].nreg = 3'd1;
    vecs[1].ridx[0] = 3'd1; vecs[1].rval[0] = 16'h0000;

    // LD/ST with negative offset
    vecs[2].name = "ldst"; vecs[2].nwords = 5'd5; vecs[2].halt_cyc = 8'd19;
    vecs[2].prog[0] = 16'h7630; vecs[2].prog[1] = 16'h75AB; vecs[2].prog[2] = 16'h94FF;
    vecs[2].prog[3] = 16'h88FF; vecs[2].prog[4] = 16'hF000;
    vecs[2].nreg = 3'd3;
    vecs[2].ridx[0] = 3'd4; vecs[2].rval[0] = 16'h01AB;
    vecs[2].ridx[1] = 3'd2; vecs[2].rval[1] = 16'h01AB;
    vecs[2].ridx[2] = 3'd3; vecs[2].rval[2] = 16'h0030;
    vecs[2].chk_mem = 1'b1; vecs[2].maddr = 16'h002F; vecs[2].mval = 16'h01AB;

    // R0 discard and subtraction wrap
    vecs[3].name = "r0wrap"; vecs[3].nwords = 5'd4; vecs[3].halt_cyc = 8'd14;
    vecs[3].prog[0] = 16'h6005; vecs[3].prog[1] = 16'h7201;
    vecs[3].prog[2] = 16'h2C08; vecs[3].prog[3] = 16'hF000;
    vecs[3].nreg = 3'd3;
    vecs[3].ridx[0] = 3'd0; vecs[3].rval[0] = 16'h0000;
    vecs[3].ridx[1] = 3'd6; vecs[3].rval[1] = 16'hFFFF;
    vecs[3].ridx[2] = 3'd1; vecs[3].rval[2] = 16'h0001;

    // Logic ops, SLL, NOP, reserved op, BEQ taken/not taken, JMP
    vecs[4].name = "logic"; vecs[4].nwords = 5'd14; vecs[4].halt_cyc = 8'd39;
    vecs[4].prog[0]  = 16'h72F3; vecs[4].prog[1]  = 16'h743C; vecs[4].prog[2]  = 16'h3650;
    vecs[4].prog[3]  = 16'h4850; vecs[4].prog[4]  = 16'h5A50; vecs[4].prog[5]  = 16'hDC44;
    vecs[4].prog[6]  = 16'h0000; vecs[4].prog[7]  = 16'hE000; vecs[4].prog[8]  = 16'hA6C1;
    vecs[4].prog[9]  = 16'hF000; vecs[4].prog[10] = 16'hC00C; vecs[4].prog[11] = 16'hF000;
    vecs[4].prog[12] = 16'hA281; vecs[4].prog[13] = 16'hF000;
    vecs[4].nreg = 3'd4;
    vecs[4].ridx[0] = 3'd3; vecs[4].rval[0] = 16'h0030;
    vecs[4].ridx[1] = 3'd4; vecs[4].rval[1] = 16'h00FF;
    vecs[4].ridx[2] = 3'd5; vecs[4].rval[2] = 16'h00CF;
    vecs[4].ridx[3] = 3'd6; vecs[4].rval[3] = 16'h0F30;

    // Self-modifying: ST of R0 turns the HLT at address 4 into a NOP
    vecs[5].name = "selfmod"; vecs[5].nwords = 5'd7; vecs[5].halt_cyc = 8'd20;
    vecs[5].prog[0] = 16'h9004; vecs[5].prog[1] = 16'h7407; vecs[5].prog[2] = 16'h0000;
    vecs[5].prog[3] = 16'h0000; vecs[5].prog[4] = 16'hF000; vecs[5].prog[5] = 16'h7609;
    vecs[5].prog[6] = 16'hF000;
    vecs[5].nreg = 3'd2;
    vecs[5].ridx[0] = 3'd3; vecs[5].rval[0] = 16'h0009;
    vecs[5].ridx[1] = 3'd2; vecs[5].rval[1] = 16'h0007;
    vecs[5].chk_mem = 1'b1; vecs[5].maddr = 16'h0004; vecs[5].mval = 16'h0000;

    for (int t = 0; t < 6; t++) begin
      run_vec(vecs[t], 1'b1);
    end

    // Halt is sticky: 10 more cycles, PC stays just past the HLT at 0005
    run_vec(vecs[0], 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("sticky_halt", {15'h0000, Halt}, 16'h0001);
    check("sticky_pc", dut.DP.PC_q, 16'h0006);
    check("sticky_ir", dut.DP.IR_q, 16'hF000);
    // Reset out of HALT reruns the same program to the same results
    run_vec(vecs[0], 1'b0);

    // Reset wins over a pending store: ST R2,[R3-1] reaches MEMORY after edge 11
    enter_reset(vecs[2], 1'b1);
    dut.DP.MEM.mem[16'h002F] = 16'h5555;
    reset = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("midrst_ir", dut.DP.IR_q, 16'h94FF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_mem_002f", dut.DP.MEM.mem[16'h002F], 16'h5555);
    check("midrst_pc", dut.DP.PC_q, 16'h0000);
    check("midrst_halt", {15'h0000, Halt}, 16'h0000);
    run_vec(vecs[2], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
